// File: rtl/flag_pkg.sv
// Shared constants and stack-operation decode for the flag shadow stack.
// Flag bit positions are fixed: bit 0 is carry, bit 1 is zero.
package flag_pkg;

  localparam int unsigned DefaultNflags = 2;
  localparam int unsigned DefaultDepth  = 4;

  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_Z = 1;

  typedef enum logic [1:0] {
    OpNone,
    OpPush,
    OpPop,
    OpBoth
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    stack_op_e op;
    unique case ({push, pop})
      2'b10:   op = OpPush;
      2'b01:   op = OpPop;
      2'b11:   op = OpBoth;
      default: op = OpNone;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/flag_lifo.sv
// Shadow storage for saved flag words: a small LIFO with level tracking.
// It flags illegal requests (overflow, underflow, push/pop collision); the caller keeps the sticky error.
module flag_lifo
  import flag_pkg::*;
#(
  parameter int unsigned Width = DefaultNflags,
  parameter int unsigned Depth = DefaultDepth,
  localparam int unsigned LvlW = $clog2(Depth + 1),
  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic [LvlW-1:0]  level_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             pop_ok_o,
  output logic             err_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [LvlW-1:0]  level_q, level_d;
  logic [IdxW-1:0]  wr_idx, rd_idx;
  stack_op_e        op;
  logic             push_ok, pop_ok;

  assign op      = decode_op(push_i, pop_i);
  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign push_ok = (op == OpPush) && !full_o;
  assign pop_ok  = (op == OpPop) && !empty_o;
  assign err_o   = (op == OpBoth) || ((op == OpPush) && full_o) || ((op == OpPop) && empty_o);

  assign wr_idx = IdxW'(level_q);
  // Read index wraps when empty; the value is only consumed on a valid pop.
  assign rd_idx = IdxW'(level_q - LvlW'(1));

  always_comb begin
    level_d = level_q;
    if (push_ok) begin
      level_d = level_q + LvlW'(1);
    end else if (pop_ok) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // Entry contents survive reset; anything at or above the level is never read.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_ok) begin
      mem_q[wr_idx] <= data_i;
    end
  end

  assign data_o   = mem_q[rd_idx];
  assign level_o  = level_q;
  assign pop_ok_o = pop_ok;

endmodule

// File: rtl/flag_shadow_stack.sv
// Live condition-flag register with per-bit set/clear/load and a shadow stack
// that saves and restores the whole flag word across nested interrupts.
module flag_shadow_stack
  import flag_pkg::*;
#(
  parameter int unsigned NFLAGS = DefaultNflags,
  parameter int unsigned DEPTH  = DefaultDepth,
  localparam int unsigned LvlW  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NFLAGS-1:0] set_i,
  input  logic [NFLAGS-1:0] clr_i,
  input  logic [NFLAGS-1:0] ld_i,
  input  logic [NFLAGS-1:0] din_i,
  input  logic              push_i,
  input  logic              pop_i,
  output logic [NFLAGS-1:0] flags_o,
  output logic [LvlW-1:0]   level_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o
);

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic              err_q, err_d;
  logic [NFLAGS-1:0] stack_top;
  logic              pop_ok, stack_err;

  flag_lifo #(
    .Width (NFLAGS),
    .Depth (DEPTH)
  ) u_lifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (push_i),
    .pop_i    (pop_i),
    .data_i   (flags_q),
    .data_o   (stack_top),
    .level_o  (level_o),
    .full_o   (full_o),
    .empty_o  (empty_o),
    .pop_ok_o (pop_ok),
    .err_o    (stack_err)
  );

  always_comb begin
    flags_d = flags_q;
    for (int i = 0; i < int'(NFLAGS); i++) begin
      if (set_i[i]) begin
        flags_d[i] = 1'b1;
      end else if (clr_i[i]) begin
        flags_d[i] = 1'b0;
      end else if (ld_i[i]) begin
        flags_d[i] = din_i[i];
      end
    end
    // A successful restore replaces the whole word, whatever the ALU asked for.
    if (pop_ok) begin
      flags_d = stack_top;
    end
    err_d = err_q | stack_err;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign flags_o = flags_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_flag_shadow_stack.sv
// Directed bench for flag_shadow_stack at NFLAGS=2, DEPTH=4 with hand-computed expectations.
module tb_flag_shadow_stack;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] set_v, clr_v, ld_v, din_v;
  logic       push, pop;
  logic [1:0] flags;
  logic [2:0] level;
  logic       full, empty, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flag_shadow_stack #(
    .NFLAGS (2),
    .DEPTH  (4)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .set_i   (set_v),
    .clr_i   (clr_v),
    .ld_i    (ld_v),
    .din_i   (din_v),
    .push_i  (push),
    .pop_i   (pop),
    .flags_o (flags),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty),
    .err_o   (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic r, input logic [1:0] s, input logic [1:0] c,
                     input logic [1:0] l, input logic [1:0] d, input logic pu, input logic po);
    rst_n = r; set_v = s; clr_v = c; ld_v = l; din_v = d; push = pu; pop = po;
    @(posedge clk);
    #1;
    rst_n = 1'b1; set_v = '0; clr_v = '0; ld_v = '0; din_v = '0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [1:0] f, input logic [2:0] lv,
                             input logic e);
    check({tag, ".flags"}, 32'(flags), 32'(f));
    check({tag, ".level"}, 32'(level), 32'(lv));
    check({tag, ".err"}, 32'(err), 32'(e));
    check({tag, ".full"}, 32'(full), 32'(lv == 3'd4));
    check({tag, ".empty"}, 32'(empty), 32'(lv == 3'd0));
  endtask

  initial begin
    rst_n = 1'b0; set_v = '0; clr_v = '0; ld_v = '0; din_v = '0; push = 1'b0; pop = 1'b0;

    cyc(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    check_state("reset", 2'b00, 3'd0, 1'b0);

    // Per-bit priority
    cyc(1'b1, 2'b00, 2'b00, 2'b11, 2'b01, 1'b0, 1'b0);
    check_state("ld", 2'b01, 3'd0, 1'b0);
    cyc(1'b1, 2'b10, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0);
    check_state("set_wins", 2'b11, 3'd0, 1'b0);
    cyc(1'b1, 2'b00, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
    check_state("clr_beats_ld", 2'b10, 3'd0, 1'b0);

    // No combinational input-to-output path
    set_v = 2'b01; push = 1'b1;
    #1;
    check_state("no_comb", 2'b10, 3'd0, 1'b0);
    set_v = '0; push = 1'b0;

    // Push saves pre-edge flags while SET still applies; pop restores
    cyc(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    check_state("push1", 2'b11, 3'd1, 1'b0);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    check_state("pop1", 2'b10, 3'd0, 1'b0);

    // Fill to depth with 01,10,11,00
    cyc(1'b1, 2'b00, 2'b00, 2'b11, 2'b01, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 2'b00, 2'b11, 2'b10, 1'b1, 1'b0);
    check_state("fill1", 2'b10, 3'd1, 1'b0);
    cyc(1'b1, 2'b00, 2'b00, 2'b11, 2'b11, 1'b1, 1'b0);
    cyc(1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    check_state("fill4", 2'b00, 3'd4, 1'b0);
    cyc(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    check_state("overflow", 2'b11, 3'd4, 1'b1);

    // Pops return in LIFO order; the first also shows pop overriding SET
    cyc(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    check_state("popA", 2'b00, 3'd3, 1'b1);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    check_state("popB", 2'b11, 3'd2, 1'b1);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    check_state("popC", 2'b10, 3'd1, 1'b1);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    check_state("popD", 2'b01, 3'd0, 1'b1);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    check_state("sticky", 2'b01, 3'd0, 1'b1);

    // Underflow from a clean state
    cyc(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    check_state("reset2", 2'b00, 3'd0, 1'b0);
    cyc(1'b1, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b1);
    check_state("underflow", 2'b11, 3'd0, 1'b1);

    // Collision at level 2, then reset mid-nesting
    cyc(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 2'b00, 2'b11, 2'b01, 1'b1, 1'b0);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    check_state("lvl2", 2'b01, 3'd2, 1'b0);
    cyc(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 1'b1);
    check_state("collide", 2'b00, 3'd2, 1'b1);
    cyc(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    check_state("reset_mid", 2'b00, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_shadow_stack.md
FLAG_SHADOW_STACK -- requirements
Module: flag_shadow_stack

Interface
REQ-001 The block SHALL take parameter NFLAGS, default 2, giving the number of live flag bits (bit 0 = C, bit 1 = Z by convention).
REQ-002 The block SHALL take parameter DEPTH, default 4, giving the number of shadow levels for nested interrupts; legal range is 1..16.
REQ-003 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 RST_N  in  1  reset; synchronous and active-low.
REQ-005 SET  in  NFLAGS  per-flag force to 1.
REQ-006 CLR  in  NFLAGS  per-flag force to 0.
REQ-007 LD  in  NFLAGS  per-flag load from DIN.
REQ-008 DIN  in  NFLAGS  ALU flag results.
REQ-009 PUSH  in  1  interrupt entry: save live flags to shadow stack.
REQ-010 POP  in  1  return from interrupt: restore live flags from stack top.
REQ-011 FLAGS  out  NFLAGS  live flag register.
REQ-012 LEVEL  out  $clog2(DEPTH+1)  number of occupied shadow levels.
REQ-013 FULL  out  1  LEVEL == DEPTH, combinational from LEVEL.
REQ-014 EMPTY  out  1  LEVEL == 0, combinational from LEVEL.
REQ-015 ERR  out  1  sticky error: overflow, underflow or PUSH+POP collision.

Function
REQ-016 Each live flag bit i SHALL update independently with priority SET[i] > CLR[i] > LD[i] > hold.
REQ-017 A valid POP (POP=1, PUSH=0, EMPTY=0) SHALL load all FLAGS from the stack top and decrement LEVEL, overriding SET/CLR/LD in that cycle.
REQ-018 A valid PUSH (PUSH=1, POP=0, FULL=0) SHALL write the pre-edge FLAGS value to entry LEVEL and increment LEVEL; SET/CLR/LD still apply to FLAGS in the same cycle.
REQ-019 PUSH while FULL SHALL leave the stack and LEVEL unchanged and set ERR; live flags follow REQ-016.
REQ-020 POP while EMPTY SHALL leave FLAGS following REQ-016, LEVEL unchanged, and set ERR.
REQ-021 PUSH and POP asserted together SHALL both be ignored and set ERR; live flags follow REQ-016.
REQ-022 ERR SHALL remain 1 until reset; no other clear path.
REQ-023 All outputs SHALL be registered or decoded from registers only; update latency is one clock edge; no combinational path from inputs to outputs.
REQ-024 Stack entries above LEVEL SHALL be don't-care and never observable on outputs.

Reset
REQ-025 With RST_N=0 at a rising edge: FLAGS=0, LEVEL=0, ERR=0; reset overrides every other input, including mid-nesting.
REQ-026 Shadow entry contents need not be cleared on reset.

Structure
REQ-027 Package flag_pkg SHALL hold default NFLAGS, DEPTH, and flag index constants FLG_C=0, FLG_Z=1.
REQ-028 The shadow storage SHALL be sub-module flag_lifo (push/pop, data, level, full/empty); live-flag priority logic stays in the top.
REQ-029 The design SHALL elaborate for NFLAGS 1..8 and DEPTH 1..16 without modification.

Verification (NFLAGS=2, DEPTH=4)
REQ-030 Reset, then LD=11 DIN=01 -> FLAGS=01 next cycle; SET=10 CLR=10 LD=10 DIN=00 -> FLAGS=11 (SET wins).
REQ-031 FLAGS=10, PUSH with SET=01 -> FLAGS=11, LEVEL=1; POP -> FLAGS=10, LEVEL=0, EMPTY=1.
REQ-032 Push 01,10,11,00 -> LEVEL=4, FULL=1; fifth PUSH -> LEVEL=4, ERR=1; four POPs return 00,11,10,01 in order.
REQ-033 POP while EMPTY with LD=11 DIN=11 -> FLAGS=11, LEVEL=0, ERR=1.
REQ-034 LEVEL=2, PUSH=POP=1 -> LEVEL=2, ERR=1; then RST_N=0 -> FLAGS=00, LEVEL=0, ERR=0.
